// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller:
// the in-flight slot record, the forward-select encoding and legal configurations.
package pipe_ctrl_pkg;

    localparam int MAX_REG_AW     = 8;
    localparam int FWD_RF         = 0;
    localparam int NSTAGE_MIN     = 2;
    localparam int NSTAGE_MAX     = 7;
    localparam int LOAD_STAGE_MIN = 1;

    // rd/rs fields are sized for the widest register file and zero-extended.
    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic [MAX_REG_AW-1:0] rs1;
        logic [MAX_REG_AW-1:0] rs2;
        logic                  use_rs1;
        logic                  use_rs2;
    } slot_t;

    function automatic bit cfg_legal(int nstage, int load_stage, int reg_aw);
        return (nstage >= NSTAGE_MIN) && (nstage <= NSTAGE_MAX) &&
               (load_stage >= LOAD_STAGE_MIN) && (load_stage <= nstage - 1) &&
               (reg_aw >= 1) && (reg_aw <= MAX_REG_AW);
    endfunction

    function automatic logic [31:0] sat_inc32(logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forward source select: youngest qualifying writer among slots
// 1..NSTAGE-1 wins; loads only qualify once their data exists (k >= LOAD_STAGE).
module fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NSTAGE     = 3,
    parameter int LOAD_STAGE = 2,
    parameter int FSEL_W     = $clog2(NSTAGE + 1)
) (
    input  logic                           use_i,
    input  logic [REG_AW-1:0]              src_i,
    input  logic [NSTAGE-1:1]              valid_i,
    input  logic [NSTAGE-1:1]              regwrite_i,
    input  logic [NSTAGE-1:1]              memread_i,
    input  logic [NSTAGE-1:1][REG_AW-1:0]  rd_i,
    output logic [FSEL_W-1:0]              sel_o
);

    // Scan oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        sel_o = FSEL_W'(FWD_RF);
        if (use_i) begin
            for (int k = NSTAGE - 1; k >= 1; k--) begin
                if (valid_i[k] && regwrite_i[k] && (rd_i[k] != '0) &&
                    (rd_i[k] == src_i) && (!memread_i[k] || (k >= LOAD_STAGE))) begin
                    sel_o = FSEL_W'(k);
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush controller tracking EX..WB in a shadow slot pipe.
// Optional event counters are built when PIPE_HAZ_STATS_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NSTAGE     = 3,
    parameter int LOAD_STAGE = 2,
    parameter int FSEL_W     = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              branch_taken,
    input  logic              mem_wait,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              id_bubble,
    output logic              flush,
    output logic [FSEL_W-1:0] fwd_a,
    output logic [FSEL_W-1:0] fwd_b
`ifdef PIPE_HAZ_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    if (!cfg_legal(NSTAGE, LOAD_STAGE, REG_AW)) begin : g_bad_cfg
        $error("pipe_hazard_ctrl: illegal NSTAGE/LOAD_STAGE/REG_AW combination");
    end

    slot_t slots_q [NSTAGE];
    slot_t slots_d [NSTAGE];
    slot_t id_rec;

    logic                          hazard;
    logic                          do_stall;
    logic                          do_flush;
    logic [NSTAGE-1:1]             s_valid;
    logic [NSTAGE-1:1]             s_wr;
    logic [NSTAGE-1:1]             s_ld;
    logic [NSTAGE-1:1][REG_AW-1:0] s_rd;
    logic [FSEL_W-1:0]             sel_a;
    logic [FSEL_W-1:0]             sel_b;
    logic                          unused_slot;

    // Loads still short of LOAD_STAGE cannot be forwarded yet.
    always_comb begin
        hazard = 1'b0;
        for (int j = 0; j < LOAD_STAGE - 1; j++) begin
            if (slots_q[j].valid && slots_q[j].memread && slots_q[j].regwrite &&
                (slots_q[j].rd[REG_AW-1:0] != '0) &&
                ((id_use_rs1 && (slots_q[j].rd[REG_AW-1:0] == id_rs1)) ||
                 (id_use_rs2 && (slots_q[j].rd[REG_AW-1:0] == id_rs2)))) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard && id_valid;
    end

    // Freeze beats flush, flush beats stall; reset forces the idle values.
    assign do_flush   = !reset && !mem_wait && branch_taken;
    assign do_stall   = !reset && !mem_wait && !branch_taken && hazard;
    assign flush      = do_flush;
    assign id_bubble  = do_stall;
    assign pc_write   = reset || (!mem_wait && !do_stall);
    assign ifid_write = reset || (!mem_wait && !do_stall);
    assign fwd_a      = reset ? FSEL_W'(FWD_RF) : sel_a;
    assign fwd_b      = reset ? FSEL_W'(FWD_RF) : sel_b;

    always_comb begin
        id_rec          = '0;
        id_rec.valid    = id_valid && !do_stall && !do_flush;
        id_rec.rd       = MAX_REG_AW'(id_rd);
        id_rec.regwrite = id_regwrite;
        id_rec.memread  = id_memread;
        id_rec.rs1      = MAX_REG_AW'(id_rs1);
        id_rec.rs2      = MAX_REG_AW'(id_rs2);
        id_rec.use_rs1  = id_use_rs1;
        id_rec.use_rs2  = id_use_rs2;

        slots_d = slots_q;
        if (!mem_wait) begin
            slots_d[0] = id_rec;
            for (int k = 1; k < NSTAGE; k++) begin
                slots_d[k] = slots_q[k-1];
            end
            if (branch_taken) begin
                slots_d[1].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                slots_q[k].valid <= 1'b0;
            end
        end else begin
            slots_q <= slots_d;
        end
    end

    always_comb begin
        for (int k = 1; k < NSTAGE; k++) begin
            s_valid[k] = slots_q[k].valid;
            s_wr[k]    = slots_q[k].regwrite;
            s_ld[k]    = slots_q[k].memread;
            s_rd[k]    = slots_q[k].rd[REG_AW-1:0];
        end
    end

    // Source fields of the oldest slot are kept for visibility only.
    assign unused_slot = ^{slots_q[NSTAGE-1].rd, slots_q[NSTAGE-1].rs1, slots_q[NSTAGE-1].rs2,
                           slots_q[NSTAGE-1].use_rs1, slots_q[NSTAGE-1].use_rs2};

    fwd_select #(.REG_AW(REG_AW), .NSTAGE(NSTAGE), .LOAD_STAGE(LOAD_STAGE), .FSEL_W(FSEL_W)) u_fwd_a (
        .use_i      (id_rec.use_rs1 & 1'b0 | slots_q[0].use_rs1),
        .src_i      (slots_q[0].rs1[REG_AW-1:0]),
        .valid_i    (s_valid),
        .regwrite_i (s_wr),
        .memread_i  (s_ld),
        .rd_i       (s_rd),
        .sel_o      (sel_a)
    );

    fwd_select #(.REG_AW(REG_AW), .NSTAGE(NSTAGE), .LOAD_STAGE(LOAD_STAGE), .FSEL_W(FSEL_W)) u_fwd_b (
        .use_i      (slots_q[0].use_rs2),
        .src_i      (slots_q[0].rs2[REG_AW-1:0]),
        .valid_i    (s_valid),
        .regwrite_i (s_wr),
        .memread_i  (s_ld),
        .rd_i       (s_rd),
        .sel_o      (sel_b)
    );

`ifdef PIPE_HAZ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    assign stall_cnt_d = do_stall ? sat_inc32(stall_cnt_q) : stall_cnt_q;
    assign flush_cnt_d = do_flush ? sat_inc32(flush_cnt_q) : flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default config (u0) and NSTAGE=4/LOAD_STAGE=3 (u1)
// share stimulus; each scenario checks the instance it targets.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       branch_taken, mem_wait;

    logic       pc_write0, ifid_write0, id_bubble0, flush0;
    logic [1:0] fwd_a0, fwd_b0;
    logic       pc_write1, ifid_write1, id_bubble1, flush1;
    logic [2:0] fwd_a1, fwd_b1;
`ifdef PIPE_HAZ_STATS_EN
    logic [31:0] stall_cnt0, flush_cnt0, stall_cnt1, flush_cnt1;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
        .mem_wait(mem_wait), .pc_write(pc_write0), .ifid_write(ifid_write0),
        .id_bubble(id_bubble0), .flush(flush0), .fwd_a(fwd_a0), .fwd_b(fwd_b0)
`ifdef PIPE_HAZ_STATS_EN
        , .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
`endif
    );

    pipe_hazard_ctrl #(.NSTAGE(4), .LOAD_STAGE(3)) u1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
        .mem_wait(mem_wait), .pc_write(pc_write1), .ifid_write(ifid_write1),
        .id_bubble(id_bubble1), .flush(flush1), .fwd_a(fwd_a1), .fwd_b(fwd_b1)
`ifdef PIPE_HAZ_STATS_EN
        , .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_valid = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0; id_memread = 0;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic rw, input logic mr);
        id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic drain();
        set_idle();
        branch_taken = 0;
        mem_wait = 0;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        reset = 1; branch_taken = 0; mem_wait = 0;
        set_idle();
        tick(); tick();
        checks++; if (pc_write0 !== 1'b1) begin errors++; $display("FAIL reset_pc_write: got %0d expected 1", pc_write0); end
        checks++; if (ifid_write0 !== 1'b1) begin errors++; $display("FAIL reset_ifid_write: got %0d expected 1", ifid_write0); end
        checks++; if (id_bubble0 !== 1'b0) begin errors++; $display("FAIL reset_id_bubble: got %0d expected 0", id_bubble0); end
        checks++; if (flush0 !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0d expected 0", flush0); end
        checks++; if (fwd_a0 !== 2'd0) begin errors++; $display("FAIL reset_fwd_a: got %0d expected 0", fwd_a0); end
        checks++; if (fwd_b0 !== 2'd0) begin errors++; $display("FAIL reset_fwd_b: got %0d expected 0", fwd_b0); end
        reset = 0;
        tick();
    endtask

    task automatic test_alu_chain();
        drain();
        set_id(1, 5'd5, 5'd1, 5'd2, 1, 1, 1, 0);
        tick();
        set_id(1, 5'd6, 5'd5, 5'd5, 1, 1, 1, 0);
        #1;
        checks++; if (pc_write0 !== 1'b1) begin errors++; $display("FAIL alu_no_stall: pc_write got %0d expected 1", pc_write0); end
        tick();
        set_idle();
        #1;
        checks++; if (fwd_a0 !== 2'd1) begin errors++; $display("FAIL alu_fwd_a: got %0d expected 1", fwd_a0); end
        checks++; if (fwd_b0 !== 2'd1) begin errors++; $display("FAIL alu_fwd_b: got %0d expected 1", fwd_b0); end
        checks++; if (fwd_a1 !== 3'd1) begin errors++; $display("FAIL alu_fwd_a_u1: got %0d expected 1", fwd_a1); end
    endtask

    task automatic test_load_use_ls2();
        drain();
        set_id(1, 5'd7, 5'd2, 5'd0, 1, 0, 1, 1);
        tick();
        set_id(1, 5'd8, 5'd7, 5'd1, 1, 1, 1, 0);
        #1;
        checks++; if (id_bubble0 !== 1'b1) begin errors++; $display("FAIL ls2_stall_bubble: got %0d expected 1", id_bubble0); end
        checks++; if (pc_write0 !== 1'b0) begin errors++; $display("FAIL ls2_stall_pc_write: got %0d expected 0", pc_write0); end
        checks++; if (ifid_write0 !== 1'b0) begin errors++; $display("FAIL ls2_stall_ifid_write: got %0d expected 0", ifid_write0); end
        tick();
        #1;
        checks++; if (id_bubble0 !== 1'b0) begin errors++; $display("FAIL ls2_release_bubble: got %0d expected 0", id_bubble0); end
        checks++; if (pc_write0 !== 1'b1) begin errors++; $display("FAIL ls2_release_pc_write: got %0d expected 1", pc_write0); end
        tick();
        set_idle();
        #1;
        checks++; if (fwd_a0 !== 2'd2) begin errors++; $display("FAIL ls2_fwd_a: got %0d expected 2", fwd_a0); end
        checks++; if (fwd_b0 !== 2'd0) begin errors++; $display("FAIL ls2_fwd_b: got %0d expected 0", fwd_b0); end
    endtask

    task automatic test_load_use_ls3();
        drain();
        set_id(1, 5'd7, 5'd2, 5'd0, 1, 0, 1, 1);
        tick();
        set_id(1, 5'd8, 5'd7, 5'd1, 1, 1, 1, 0);
        #1;
        checks++; if (id_bubble1 !== 1'b1) begin errors++; $display("FAIL ls3_stall1: bubble got %0d expected 1", id_bubble1); end
        tick();
        checks++; if (id_bubble1 !== 1'b1) begin errors++; $display("FAIL ls3_stall2: bubble got %0d expected 1", id_bubble1); end
        checks++; if (pc_write1 !== 1'b0) begin errors++; $display("FAIL ls3_stall2_pc_write: got %0d expected 0", pc_write1); end
        tick();
        checks++; if (id_bubble1 !== 1'b0) begin errors++; $display("FAIL ls3_release: bubble got %0d expected 0", id_bubble1); end
        checks++; if (pc_write1 !== 1'b1) begin errors++; $display("FAIL ls3_release_pc_write: got %0d expected 1", pc_write1); end
        tick();
        set_idle();
        #1;
        checks++; if (fwd_a1 !== 3'd3) begin errors++; $display("FAIL ls3_fwd_a: got %0d expected 3", fwd_a1); end
    endtask

    task automatic test_two_writers();
        drain();
        set_id(1, 5'd9, 5'd0, 5'd0, 0, 0, 1, 0);
        tick();
        set_id(1, 5'd9, 5'd0, 5'd0, 0, 0, 1, 0);
        tick();
        set_id(1, 5'd10, 5'd9, 5'd9, 1, 0, 1, 0);
        tick();
        set_idle();
        #1;
        checks++; if (fwd_a0 !== 2'd1) begin errors++; $display("FAIL youngest_wins: fwd_a got %0d expected 1", fwd_a0); end
        checks++; if (fwd_b0 !== 2'd0) begin errors++; $display("FAIL unused_operand: fwd_b got %0d expected 0", fwd_b0); end
        drain();
        set_id(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0);
        tick();
        set_id(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1);
        tick();
        set_id(1, 5'd11, 5'd0, 5'd0, 1, 1, 1, 0);
        #1;
        checks++; if (pc_write0 !== 1'b1) begin errors++; $display("FAIL x0_no_hazard: pc_write got %0d expected 1", pc_write0); end
        tick();
        set_idle();
        #1;
        checks++; if (fwd_a0 !== 2'd0) begin errors++; $display("FAIL x0_fwd_a: got %0d expected 0", fwd_a0); end
        checks++; if (fwd_b0 !== 2'd0) begin errors++; $display("FAIL x0_fwd_b: got %0d expected 0", fwd_b0); end
    endtask

    task automatic test_flush_over_stall();
        drain();
        set_id(1, 5'd7, 5'd2, 5'd0, 1, 0, 1, 1);
        tick();
        set_id(1, 5'd8, 5'd7, 5'd0, 1, 0, 1, 0);
        #1;
        checks++; if (id_bubble0 !== 1'b1) begin errors++; $display("FAIL flush_pre_stall: bubble got %0d expected 1", id_bubble0); end
        branch_taken = 1;
        #1;
        checks++; if (flush0 !== 1'b1) begin errors++; $display("FAIL flush_asserted: got %0d expected 1", flush0); end
        checks++; if (pc_write0 !== 1'b1) begin errors++; $display("FAIL flush_pc_write: got %0d expected 1", pc_write0); end
        checks++; if (id_bubble0 !== 1'b0) begin errors++; $display("FAIL flush_bubble: got %0d expected 0", id_bubble0); end
        checks++; if (ifid_write0 !== 1'b1) begin errors++; $display("FAIL flush_ifid_write: got %0d expected 1", ifid_write0); end
        tick();
        branch_taken = 0;
        set_id(1, 5'd9, 5'd8, 5'd7, 1, 1, 1, 0);
        #1;
        checks++; if (pc_write0 !== 1'b1) begin errors++; $display("FAIL flush_slot0_invalid: pc_write got %0d expected 1", pc_write0); end
        tick();
        set_idle();
        #1;
        checks++; if (fwd_a0 !== 2'd0) begin errors++; $display("FAIL flush_killed_id: fwd_a got %0d expected 0", fwd_a0); end
        checks++; if (fwd_b0 !== 2'd0) begin errors++; $display("FAIL flush_killed_ex: fwd_b got %0d expected 0", fwd_b0); end
    endtask

    task automatic test_freeze();
        drain();
        set_id(1, 5'd7, 5'd2, 5'd0, 1, 0, 1, 1);
        tick();
        set_id(1, 5'd8, 5'd7, 5'd1, 1, 1, 1, 0);
        #1;
        checks++; if (id_bubble1 !== 1'b1) begin errors++; $display("FAIL frz_pre_stall: bubble got %0d expected 1", id_bubble1); end
        tick();
        mem_wait = 1;
        #1;
        checks++; if (pc_write1 !== 1'b0) begin errors++; $display("FAIL frz_pc_write: got %0d expected 0", pc_write1); end
        checks++; if (ifid_write1 !== 1'b0) begin errors++; $display("FAIL frz_ifid_write: got %0d expected 0", ifid_write1); end
        checks++; if (id_bubble1 !== 1'b0) begin errors++; $display("FAIL frz_bubble: got %0d expected 0", id_bubble1); end
        tick();
        checks++; if (pc_write1 !== 1'b0) begin errors++; $display("FAIL frz_cycle2_pc_write: got %0d expected 0", pc_write1); end
        tick();
        branch_taken = 1;
        #1;
        checks++; if (flush1 !== 1'b0) begin errors++; $display("FAIL frz_beats_flush: flush got %0d expected 0", flush1); end
        branch_taken = 0;
        tick();
        mem_wait = 0;
        #1;
        checks++; if (id_bubble1 !== 1'b1) begin errors++; $display("FAIL frz_stall_resumes: bubble got %0d expected 1", id_bubble1); end
        tick();
        checks++; if (id_bubble1 !== 1'b0) begin errors++; $display("FAIL frz_release: bubble got %0d expected 0", id_bubble1); end
        tick();
        set_idle();
        #1;
        checks++; if (fwd_a1 !== 3'd3) begin errors++; $display("FAIL frz_fwd_a: got %0d expected 3", fwd_a1); end
    endtask

    task automatic test_reset_mid();
        drain();
        set_id(1, 5'd7, 5'd2, 5'd0, 1, 0, 1, 1);
        tick();
        set_id(1, 5'd8, 5'd7, 5'd0, 1, 0, 1, 0);
        #1;
        checks++; if (id_bubble0 !== 1'b1) begin errors++; $display("FAIL rstmid_pre_stall: bubble got %0d expected 1", id_bubble0); end
        reset = 1;
        #1;
        checks++; if (id_bubble0 !== 1'b0) begin errors++; $display("FAIL rstmid_bubble: got %0d expected 0", id_bubble0); end
        tick();
        reset = 0;
        #1;
        checks++; if (pc_write0 !== 1'b1) begin errors++; $display("FAIL rstmid_slots_cleared: pc_write got %0d expected 1", pc_write0); end
        tick();
        set_idle();
        #1;
        checks++; if (fwd_a0 !== 2'd0) begin errors++; $display("FAIL rstmid_fwd_a: got %0d expected 0", fwd_a0); end
    endtask

`ifdef PIPE_HAZ_STATS_EN
    task automatic load_use_episode();
        set_id(1, 5'd7, 5'd2, 5'd0, 1, 0, 1, 1);
        tick();
        set_id(1, 5'd8, 5'd7, 5'd0, 1, 0, 1, 0);
        tick(); tick(); tick();
        set_idle();
    endtask

    task automatic test_stats();
        drain();
        reset = 1;
        tick();
        reset = 0;
        load_use_episode();
        load_use_episode();
        branch_taken = 1;
        tick(); tick();
        branch_taken = 0;
        #1;
        checks++; if (stall_cnt1 !== 32'd4) begin errors++; $display("FAIL stats_stall_cnt: got %0d expected 4", stall_cnt1); end
        checks++; if (flush_cnt1 !== 32'd2) begin errors++; $display("FAIL stats_flush_cnt: got %0d expected 2", flush_cnt1); end
        reset = 1;
        tick();
        checks++; if (stall_cnt1 !== 32'd0) begin errors++; $display("FAIL stats_stall_reset: got %0d expected 0", stall_cnt1); end
        checks++; if (flush_cnt1 !== 32'd0) begin errors++; $display("FAIL stats_flush_reset: got %0d expected 0", flush_cnt1); end
        reset = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_alu_chain();
        test_load_use_ls2();
        test_load_use_ls3();
        test_two_writers();
        test_flush_over_stall();
        test_freeze();
        test_reset_mid();
`ifdef PIPE_HAZ_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
